// File: rtl/param_shift_pipe.sv
// ---------------------------------------------------------------------------
// param_shift_pipe
//   WIDTH x DEPTH register delay line. It supports shift, hold, parallel load,
//   synchronous clear and a selectable observation tap. All stages update
//   together on one edge, and each stage takes its source's pre-edge value.
//
// Ports
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   clr       synchronous clear; overrides op
//   op        00 hold, 01 shift, 10 parallel load, 11 rotate or hold
//   din       serial input to stage 0
//   pload     parallel load data; slice [i*WIDTH +: WIDTH] goes to stage i
//   tap_sel   stage index shown on tap_out (out of range gives 0)
//   dout      stage DEPTH-1
//   tap_out   stage[tap_sel]
//   stages    all stages flattened, using the same slicing as pload
//   fill_cnt  count of stages holding valid data, 0..DEPTH
//   full      fill_cnt == DEPTH
//
// Build option
//   SHIFT_ROTATE_EN : when defined, op=11 rotates stage DEPTH-1 into stage 0.
//                     When undefined, op=11 behaves as hold.
// ---------------------------------------------------------------------------
module param_shift_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned TAP_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clr,
    input  logic [1:0]             op,
    input  logic [WIDTH-1:0]       din,
    input  logic [DEPTH*WIDTH-1:0] pload,
    input  logic [TAP_W-1:0]       tap_sel,
    output logic [WIDTH-1:0]       dout,
    output logic [WIDTH-1:0]       tap_out,
    output logic [DEPTH*WIDTH-1:0] stages,
    output logic [CNT_W-1:0]       fill_cnt,
    output logic                   full
);

    localparam logic [1:0] OP_HOLD  = 2'b00;
    localparam logic [1:0] OP_SHIFT = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
`ifdef SHIFT_ROTATE_EN
    localparam logic [1:0] OP_ROT   = 2'b11;
`endif

    // Packed [stage][bit] storage. Flattening it gives the pload/stages slicing.
    logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;
    logic [CNT_W-1:0]            fill_q, fill_d;

    // Next-state selection. clr takes priority over every op.
    always_comb begin
        stage_d = stage_q;
        fill_d  = fill_q;
        if (clr) begin
            stage_d = '0;
            fill_d  = '0;
        end else begin
            case (op)
                OP_HOLD: begin
                end
                OP_SHIFT: begin
                    stage_d[0] = din;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        stage_d[i] = stage_q[i-1];
                    end
                    // The fill count saturates at DEPTH and never wraps.
                    if (fill_q != CNT_W'(DEPTH)) begin
                        fill_d = fill_q + CNT_W'(1);
                    end
                end
                OP_LOAD: begin
                    stage_d = pload;
                    fill_d  = CNT_W'(DEPTH);
                end
`ifdef SHIFT_ROTATE_EN
                OP_ROT: begin
                    stage_d[0] = stage_q[DEPTH-1];
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        stage_d[i] = stage_q[i-1];
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    // Stage and fill registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_q <= '0;
            fill_q  <= '0;
        end else begin
            stage_q <= stage_d;
            fill_q  <= fill_d;
        end
    end

    // Tap mux. An index with no matching stage (non-power-of-2 DEPTH) reads 0.
    always_comb begin
        tap_out = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (tap_sel == TAP_W'(i)) begin
                tap_out = stage_q[i];
            end
        end
    end

    assign dout     = stage_q[DEPTH-1];
    assign stages   = stage_q;
    assign fill_cnt = fill_q;
    assign full     = (fill_q == CNT_W'(DEPTH));

endmodule

// File: tb/tb_param_shift_pipe.sv
// ---------------------------------------------------------------------------
// tb_param_shift_pipe
//   Directed bench. It drives a DEPTH=4 instance and a DEPTH=3 instance
//   (used for the tap range test), both with WIDTH=8. Expected values are
//   hand-computed constants.
// ---------------------------------------------------------------------------
module tb_param_shift_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clr;
    logic [1:0]  op;
    logic [7:0]  din;
    logic [31:0] pload;
    logic [1:0]  tap_sel;
    logic [7:0]  dout, tap_out;
    logic [31:0] stages;
    logic [2:0]  fill_cnt;
    logic        full;

    logic [1:0]  op3;
    logic [7:0]  din3;
    logic [23:0] pload3;
    logic [1:0]  tap_sel3;
    logic [7:0]  dout3, tap_out3;
    logic [23:0] stages3;
    logic [1:0]  fill_cnt3;
    logic        full3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    param_shift_pipe #(.WIDTH(8), .DEPTH(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .clr(clr), .op(op), .din(din),
        .pload(pload), .tap_sel(tap_sel), .dout(dout), .tap_out(tap_out),
        .stages(stages), .fill_cnt(fill_cnt), .full(full)
    );

    param_shift_pipe #(.WIDTH(8), .DEPTH(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .clr(clr), .op(op3), .din(din3),
        .pload(pload3), .tap_sel(tap_sel3), .dout(dout3), .tap_out(tap_out3),
        .stages(stages3), .fill_cnt(fill_cnt3), .full(full3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Apply the current inputs on one rising edge, then settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; clr = 1'b0; op = 2'b00; din = '0; pload = '0; tap_sel = '0;
        op3 = 2'b00; din3 = '0; pload3 = '0; tap_sel3 = '0;
        #12;
        chk("rst_stages", stages, 32'h0);
        chk("rst_fill",   32'(fill_cnt), 32'd0);
        chk("rst_full",   32'(full), 32'd0);
        reset_n = 1'b1;
        step();

        // Shift in four bytes. The pipeline is full only after the 4th shift edge.
        op = 2'b01;
        din = 8'h11; step();
        chk("sh1_fill", 32'(fill_cnt), 32'd1);
        chk("sh1_full", 32'(full), 32'd0);
        din = 8'h22; step();
        din = 8'h33; step();
        chk("sh3_full", 32'(full), 32'd0);
        din = 8'h44; step();
        chk("sh4_stages", stages, 32'h11223344);
        chk("sh4_dout",   32'(dout), 32'h11);
        chk("sh4_full",   32'(full), 32'd1);
        din = 8'h55; step();
        chk("sh5_dout", 32'(dout), 32'h22);
        chk("sh5_fill", 32'(fill_cnt), 32'd4);
        chk("sh5_stages", stages, 32'h22334455);

        // Assert reset mid-stream. The outputs clear before the next edge.
        op = 2'b00;
        #1 reset_n = 1'b0;
        #1;
        chk("arst_stages", stages, 32'h0);
        chk("arst_dout",   32'(dout), 32'h0);
        chk("arst_tap",    32'(tap_out), 32'h0);
        chk("arst_fill",   32'(fill_cnt), 32'd0);
        chk("arst_full",   32'(full), 32'd0);
        reset_n = 1'b1;
        step();

        // Holds freeze the pipeline. A reaches dout on its 4th shift edge.
        op = 2'b01; din = 8'hA5; step();
        op = 2'b00; step(); step(); step();
        chk("hold_stages", stages, 32'h000000A5);
        chk("hold_fill",   32'(fill_cnt), 32'd1);
        op = 2'b01; din = 8'h00; step(); step();
        chk("lat_dout_early", 32'(dout), 32'h00);
        step();
        chk("lat_dout", 32'(dout), 32'hA5);
        chk("lat_fill", 32'(fill_cnt), 32'd4);

        // Parallel load, then clr overrides a load on the same edge.
        op = 2'b10; pload = 32'hDDCCBBAA; step();
        chk("ld_stages", stages, 32'hDDCCBBAA);
        chk("ld_fill",   32'(fill_cnt), 32'd4);
        chk("ld_dout",   32'(dout), 32'hDD);
        tap_sel = 2'd1; #1;
        chk("ld_tap1", 32'(tap_out), 32'hBB);
        clr = 1'b1; pload = 32'h12345678; step();
        chk("clr_stages", stages, 32'h0);
        chk("clr_fill",   32'(fill_cnt), 32'd0);
        chk("clr_full",   32'(full), 32'd0);
        clr = 1'b0;

        // op=11 after a load.
        op = 2'b10; pload = 32'hDDCCBBAA; step();
        op = 2'b11; step();
`ifdef SHIFT_ROTATE_EN
        chk("op11_stages", stages, 32'hCCBBAADD);
`else
        chk("op11_stages", stages, 32'hDDCCBBAA);
`endif
        chk("op11_fill", 32'(fill_cnt), 32'd4);
        op = 2'b00;

        // DEPTH=3: a tap index past the last stage reads 0.
        op3 = 2'b10; pload3 = 24'h332211; step();
        op3 = 2'b00;
        chk("d3_fill",   32'(fill_cnt3), 32'd3);
        chk("d3_full",   32'(full3), 32'd1);
        chk("d3_dout",   32'(dout3), 32'h33);
        chk("d3_stages", 32'(stages3), 32'h00332211);
        tap_sel3 = 2'd0; #1; chk("d3_tap0", 32'(tap_out3), 32'h11);
        tap_sel3 = 2'd1; #1; chk("d3_tap1", 32'(tap_out3), 32'h22);
        tap_sel3 = 2'd2; #1; chk("d3_tap2", 32'(tap_out3), 32'h33);
        tap_sel3 = 2'd3; #1; chk("d3_tap3", 32'(tap_out3), 32'h00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
